// File: rtl/mult3_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : mult3_stim_gen
// Purpose  : Stimulus and golden-reference generator for a 4-bit
//            divisible-by-3 detector. Sweeps words onto A..D under a
//            valid/ready handshake; EXPECT comes from a running mod-3
//            residue counter rather than from decoding the word.
// Revision : 1.0  initial release
// ============================================================================
module mult3_stim_gen #(
  parameter int PASSES = 1          // complete sweeps per START, 1..255
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic START,
  input  logic MODE,
  input  logic ABORT,
  input  logic READY,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic VALID,
  output logic EXPECT,
  output logic BUSY,
  output logic DONE
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);
  localparam logic [3:0] LAST_WORD = 4'd15;

  state_t     state,       state_nxt;
  logic [3:0] word,        word_nxt;
  logic [1:0] residue,     residue_nxt;
  logic [7:0] pass,        pass_nxt;
  logic       mode_q,      mode_nxt;
  logic       valid_q,     valid_nxt;
  logic       expect_q,    expect_nxt;
  logic       busy_q,      busy_nxt;
  logic       done_q,      done_nxt;

  logic       xfer;
  logic [1:0] residue_inc;

  assign xfer = valid_q & READY;

  // Residue step for the all-words sweep; the unreachable code 3 counts as 0.
  always_comb begin
    residue_inc = 2'd0;
    case (residue)
      2'd0:    residue_inc = 2'd1;
      2'd1:    residue_inc = 2'd2;
      default: residue_inc = (residue == 2'd3) ? 2'd1 : 2'd0;
    endcase
  end

  // State and datapath registers; every output is driven straight from here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      word     <= 4'd0;
      residue  <= 2'd0;
      pass     <= 8'd0;
      mode_q   <= 1'b0;
      valid_q  <= 1'b0;
      expect_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      word     <= word_nxt;
      residue  <= residue_nxt;
      pass     <= pass_nxt;
      mode_q   <= mode_nxt;
      valid_q  <= valid_nxt;
      expect_q <= expect_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  // Next-state logic: start, advance on transfer, pass wrap, finish, abort.
  always_comb begin
    state_nxt   = state;
    word_nxt    = word;
    residue_nxt = residue;
    pass_nxt    = pass;
    mode_nxt    = mode_q;
    valid_nxt   = valid_q;
    expect_nxt  = expect_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (START) begin
          state_nxt   = RUN;
          mode_nxt    = MODE;
          word_nxt    = 4'd0;
          residue_nxt = 2'd0;
          pass_nxt    = 8'd0;
          valid_nxt   = 1'b1;
          busy_nxt    = 1'b1;
          expect_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (ABORT || (xfer && word == LAST_WORD && pass == LAST_PASS)) begin
          // Abort wins over a same-cycle transfer; only a real finish pulses DONE.
          state_nxt   = IDLE;
          word_nxt    = 4'd0;
          residue_nxt = 2'd0;
          pass_nxt    = 8'd0;
          mode_nxt    = 1'b0;
          valid_nxt   = 1'b0;
          busy_nxt    = 1'b0;
          expect_nxt  = 1'b0;
          done_nxt    = !ABORT;
        end else if (xfer) begin
          if (word == LAST_WORD) begin
            // Next pass starts on the very next cycle, no bubble.
            word_nxt    = 4'd0;
            residue_nxt = 2'd0;
            pass_nxt    = pass + 8'd1;
          end else if (mode_q) begin
            word_nxt    = word + 4'd3;
            residue_nxt = 2'd0;
          end else begin
            word_nxt    = word + 4'd1;
            residue_nxt = residue_inc;
          end
          expect_nxt = (residue_nxt == 2'd0) || (residue_nxt == 2'd3);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign A      = word[3];
  assign B      = word[2];
  assign C      = word[1];
  assign D      = word[0];
  assign VALID  = valid_q;
  assign EXPECT = expect_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mult3_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult3_stim_gen
// Purpose  : Directed self-checking bench for mult3_stim_gen, with a
//            single-pass and a three-pass instance sharing clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult3_stim_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  logic mode = 1'b0, abort = 1'b0, ready = 1'b0;

  logic a1, b1, c1, d1, valid1, expect1, busy1, done1;
  logic a3, b3, c3, d3, valid3, expect3, busy3, done3;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_pat = 16'b1001001001001001;
  logic [3:0]  m1_words [6] = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15};

  always #5 clk = ~clk;

  mult3_stim_gen #(.PASSES(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .MODE(mode), .ABORT(abort),
    .READY(ready), .A(a1), .B(b1), .C(c1), .D(d1), .VALID(valid1),
    .EXPECT(expect1), .BUSY(busy1), .DONE(done1)
  );

  mult3_stim_gen #(.PASSES(3)) dut3 (
    .CLK(clk), .RST_N(rst_n), .START(start3), .MODE(mode), .ABORT(abort),
    .READY(ready), .A(a3), .B(b3), .C(c3), .D(d3), .VALID(valid3),
    .EXPECT(expect3), .BUSY(busy3), .DONE(done3)
  );

  wire [3:0] word1 = {a1, b1, c1, d1};
  wire [3:0] word3 = {a3, b3, c3, d3};
  wire [7:0] outs1 = {word1, valid1, expect1, busy1, done1};
  wire [7:0] outs3 = {word3, valid3, expect3, busy3, done3};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Reference divisible-by-3 detector for the integration check.
  function automatic logic det3(input logic [3:0] w);
    return (w % 3) == 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int done_cnt;

    // ---------------- reset ----------------
    #2 rst_n = 1'b0;
    #2;
    check_val("reset_outs1", outs1, 8'd0);
    check_val("reset_outs3", outs3, 8'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check_val("idle_outs1", outs1, 8'd0);

    // ---------------- MODE=0, PASSES=1, READY=1 ----------------
    start1 = 1'b1; mode = 1'b0; ready = 1'b1;
    tick;
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("m0_word%0d", i), {4'd0, word1}, 8'(i));
      check_val($sformatf("m0_exp%0d", i), {7'd0, expect1}, {7'd0, exp_pat[i]});
      check_val($sformatf("m0_det%0d", i), {7'd0, expect1}, {7'd0, det3(word1)});
      check_val($sformatf("m0_vb%0d", i), {6'd0, valid1, busy1}, 8'd3);
      check_val($sformatf("m0_nodone%0d", i), {7'd0, done1}, 8'd0);
      tick;
    end
    check_val("m0_done", outs1, 8'd1);
    // START on the DONE cycle is honoured
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    check_val("m0_done_pulse_end", {7'd0, done1}, 8'd0);
    check_val("restart_on_done", outs1, 8'b0000_1110);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_val("abort_clean", outs1, 8'd0);

    // ---------------- MODE=1 with READY toggling ----------------
    mode = 1'b1; start1 = 1'b1; ready = 1'b1;
    tick;
    start1 = 1'b0; mode = 1'b0;   // mode change during run must be ignored
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 6; cyc++) begin
      ready = (cyc % 2 == 0);
      start1 = (cyc == 3);        // START during run must be ignored
      check_val($sformatf("m1_word_c%0d", cyc), {4'd0, word1}, {4'd0, m1_words[idx]});
      check_val($sformatf("m1_exp_c%0d", cyc), {7'd0, expect1}, 8'd1);
      check_val($sformatf("m1_det_c%0d", cyc), {7'd0, det3(word1)}, {7'd0, expect1});
      check_val($sformatf("m1_valid_c%0d", cyc), {7'd0, valid1}, 8'd1);
      tick;
      if (ready) idx++;
    end
    start1 = 1'b0;
    check_val("m1_xfers", 8'(idx), 8'd6);
    check_val("m1_done", outs1, 8'd1);
    ready = 1'b1;
    tick;
    check_val("m1_idle", outs1, 8'd0);

    // ---------------- PASSES=3, back-to-back ----------------
    start3 = 1'b1; mode = 1'b0; ready = 1'b1;
    tick;
    start3 = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 48; i++) begin
      check_val($sformatf("p3_word%0d", i), {4'd0, word3}, 8'(i % 16));
      check_val($sformatf("p3_exp%0d", i), {7'd0, expect3}, {7'd0, exp_pat[i % 16]});
      check_val($sformatf("p3_valid%0d", i), {7'd0, valid3}, 8'd1);
      if (done3) done_cnt++;
      tick;
    end
    check_val("p3_done", outs3, 8'd1);
    tick;
    check_val("p3_idle", outs3, 8'd0);
    check_val("p3_early_done", 8'(done_cnt), 8'd0);
    check_val("p3_dut1_quiet", outs1, 8'd0);

    // ---------------- ABORT at word 7 ----------------
    start1 = 1'b1; mode = 1'b0; ready = 1'b1;
    tick;
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    check_val("ab_word7", {4'd0, word1}, 8'd7);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_val("ab_outs", outs1, 8'd0);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done1) done_cnt++;
      tick;
    end
    check_val("ab_no_done", 8'(done_cnt), 8'd0);
    abort = 1'b1;                 // abort in idle: no effect
    start1 = 1'b1;
    tick;
    abort = 1'b0; start1 = 1'b0;
    check_val("ab_restart", outs1, 8'b0000_1110);

    // ---------------- async reset at word 9 ----------------
    for (int i = 0; i < 9; i++) tick;
    check_val("rs_word9", {4'd0, word1}, 8'd9);
    #2 rst_n = 1'b0;
    #1;
    check_val("rs_async_outs", outs1, 8'd0);
    tick;
    rst_n = 1'b1;
    tick;
    check_val("rs_idle", outs1, 8'd0);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    check_val("rs_restart", outs1, 8'b0000_1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mult3_stim_gen.md
Name: mult3_stim_gen

Overview:
Sequential stimulus and golden-reference generator for the 4-bit divisible-by-3 detector. It sweeps 4-bit words onto four single-bit outputs A (MSB) to D (LSB), which wire directly to the detector's inputs. Alongside each word it gives the expected detector result, computed by a running mod-3 residue counter rather than by decode logic. A valid/ready handshake paces the sweep, so a checker or bench can consume one word per accepted transfer.

Parameters:
PASSES, 1, number of complete sweeps per START (legal 1..255)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  begin a run; honoured only in IDLE
MODE  input  1  sampled with START: 0 = all 16 words, 1 = multiples of 3 only
ABORT  input  1  synchronous cancel of a run in progress
READY  input  1  consumer accepts current word
A  output  1  word bit 3 (MSB)
B  output  1  word bit 2
C  output  1  word bit 1
D  output  1  word bit 0 (LSB)
VALID  output  1  A..D and EXPECT are presented
EXPECT  output  1  golden detector output for the presented word
BUSY  output  1  high in RUN
DONE  output  1  one-cycle pulse after the last word of the last pass is accepted

Behaviour:
- Reset is asynchronous on RST_N low, released synchronously to CLK.
  - State goes to IDLE.
  - All outputs are 0.
  - Word, residue, pass counter and mode register are all 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Two states of the FSM:
  - IDLE -> RUN on START=1.
  - RUN -> IDLE on ABORT=1, or after the final transfer (see below).
- IDLE with START=1:
  - Latch MODE.
  - Load word=0, residue=0, pass=0.
  - Next cycle: BUSY=1, VALID=1 with word 0 and EXPECT=1.
  - First word appears 1 cycle after START.
- In RUN, VALID stays 1 and A..D/EXPECT are held stable until a transfer (VALID&READY at a rising edge).
- READY low stalls indefinitely with no change.
- Advance rules on a transfer:
  - MODE=0: word+1; residue goes 0->1->2->0.
  - MODE=1: word+3; residue stays 0.
- EXPECT is always (residue==0).
  - MODE=0 sequence: 0..15 with EXPECT 1,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1.
  - MODE=1 sequence: 0,3,6,9,12,15, all with EXPECT=1.
- The last word of a pass is 15 in both modes. On its transfer:
  - If pass < PASSES-1: word wraps to 0, residue is cleared to 0, pass+1, and VALID stays high. There is no bubble: the next word is 0 on the following cycle.
  - If pass == PASSES-1: the next cycle has VALID=0, BUSY=0 and DONE=1 for exactly one cycle, then the state is IDLE.
- Throughput: one word per cycle while READY is held high.
  - MODE=0, PASSES=1: 16 transfers, DONE on cycle 17 after the first VALID.
- ABORT in RUN takes priority over a same-cycle transfer.
  - Next cycle: VALID=0, BUSY=0, DONE stays 0, state IDLE.
  - Counters clear to 0.
- ABORT in IDLE has no effect.
- START while in RUN is ignored. START coinciding with DONE (already in IDLE) is honoured.
- MODE changes during RUN are ignored.
- If RST_N asserts mid-run, outputs drop to 0 immediately (asynchronously), with no DONE.
- Residue is a 2-bit counter and must never reach 3. The value 3 is unreachable; if ever decoded it is treated as 0.

Test Plan:
- Reset then START, MODE=0, READY=1, PASSES=1 -> words 0..15 on consecutive cycles, EXPECT pattern 1001001001001001, DONE pulse 1 cycle after word 15, then IDLE.
- START, MODE=1 with READY toggled 1,0,1,0 -> words 0,3,6,9,12,15 with EXPECT=1, each held stable through READY-low cycles, 6 transfers, then DONE.
- PASSES=3, MODE=0, READY=1 -> 48 back-to-back transfers; word 15 is followed directly by 0 with no VALID gap; residue restarts at 0 (EXPECT=1); single DONE at the end.
- ABORT asserted with READY=1 while word 7 is presented -> next cycle VALID=0, BUSY=0, DONE never pulses; a new START restarts at word 0.
- RST_N pulsed low while word 9 is presented -> outputs go to 0 without a clock edge; after release the block is idle and a START gives word 0.
- Integration: connect A..D to the detector and consume every VALID word in both modes -> detector output equals EXPECT on every accepted word.
